// File: rtl/sad_best_match.sv
// Tracks the minimum-SAD candidate over one search window and publishes the winning
// coordinates as zero-extended 32-bit words. Build option SAD_TIE_LAST_EN: later candidate wins ties.
module sad_best_match #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               SadValid,
  input  logic               SadLast,
  input  logic [31:0]        SadValue,
  input  logic [COORD_W-1:0] SadX,
  input  logic [COORD_W-1:0] SadY,
  output logic [31:0]        BestX,
  output logic [31:0]        BestY,
  output logic [31:0]        BestSad,
  output logic [CNT_W-1:0]   CandCount,
  output logic               Busy,
  output logic               Done
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEARCH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [31:0]        run_sad_q, run_sad_d;
  logic [COORD_W-1:0] run_x_q, run_x_d;
  logic [COORD_W-1:0] run_y_q, run_y_d;
  logic [31:0]        best_x_q, best_x_d;
  logic [31:0]        best_y_q, best_y_d;
  logic [31:0]        best_sad_q, best_sad_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               take_s;
  logic [31:0]        min_sad_s;
  logic [COORD_W-1:0] min_x_s;
  logic [COORD_W-1:0] min_y_s;

  // Candidate vs running minimum; the resulting minimum also feeds the publish path.
  always_comb begin
`ifdef SAD_TIE_LAST_EN
    take_s = (SadValue <= run_sad_q);
`else
    take_s = (SadValue < run_sad_q);
`endif
    min_sad_s = take_s ? SadValue : run_sad_q;
    min_x_s   = take_s ? SadX     : run_x_q;
    min_y_s   = take_s ? SadY     : run_y_q;
  end

  // Next-state logic for the search FSM and all registered outputs.
  always_comb begin
    state_d    = state_q;
    run_sad_d  = run_sad_q;
    run_x_d    = run_x_q;
    run_y_d    = run_y_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    best_sad_d = best_sad_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = SEARCH;
          run_sad_d = 32'hFFFF_FFFF;
          run_x_d   = {COORD_W{1'b0}};
          run_y_d   = {COORD_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          busy_d    = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      SEARCH: begin
        if (SadValid) begin
          cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          run_sad_d = min_sad_s;
          run_x_d   = min_x_s;
          run_y_d   = min_y_s;
          if (SadLast) begin
            best_sad_d = min_sad_s;
            best_x_d   = {{(32-COORD_W){1'b0}}, min_x_s};
            best_y_d   = {{(32-COORD_W){1'b0}}, min_y_s};
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            busy_d = 1'b1;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      run_sad_q  <= 32'hFFFF_FFFF;
      run_x_q    <= {COORD_W{1'b0}};
      run_y_q    <= {COORD_W{1'b0}};
      best_x_q   <= 32'h0000_0000;
      best_y_q   <= 32'h0000_0000;
      best_sad_q <= 32'hFFFF_FFFF;
      cnt_q      <= {CNT_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_sad_q  <= run_sad_d;
      run_x_q    <= run_x_d;
      run_y_q    <= run_y_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      best_sad_q <= best_sad_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign BestX     = best_x_q;
  assign BestY     = best_y_q;
  assign BestSad   = best_sad_q;
  assign CandCount = cnt_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule
